// File: rtl/fd_pipe_reg_if.sv
// Fetch-to-decode bus: fetch-side inputs plus hazard controls toward the F/D
// register, and the registered decode-stage view coming back.
interface fd_pipe_reg_if;
  logic        stall;
  logic        flush;
  logic        is_jb_D;
  logic [31:0] IR_F;
  logic [31:0] pc_F;
  logic [31:0] pc4_F;
  logic [31:0] IR_D;
  logic [31:0] pc_D;
  logic [31:0] pc4_D;
  logic        valid_D;
  logic        bd_D;
  logic [4:0]  exc_D;
  logic [31:0] fetch_cnt;

  modport master (
    output stall, flush, is_jb_D, IR_F, pc_F, pc4_F,
    input  IR_D, pc_D, pc4_D, valid_D, bd_D, exc_D, fetch_cnt
  );

  modport slave (
    input  stall, flush, is_jb_D, IR_F, pc_F, pc4_F,
    output IR_D, pc_D, pc4_D, valid_D, bd_D, exc_D, fetch_cnt
  );
endinterface

// File: rtl/fd_pipe_reg.sv
// F/D pipeline register of the 5-stage MIPS core: captures IR/PC/PC+4 each
// cycle with stall/flush, tags delay slots and fetch-address errors, counts fetches.
module fd_pipe_reg #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input logic         clk,
  input logic         reset,
  fd_pipe_reg_if.slave fd
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  // Highest legal word address, widened so the bound cannot wrap past 2^32.
  localparam logic [32:0] IM_LAST = {1'b0, IM_BASE} + (33'(IM_WORDS) * 33'd4) - 33'd4;

  function automatic logic addr_bad(input logic [31:0] pc);
    logic [32:0] pc_w;
    pc_w = {1'b0, pc};
    return (pc[1:0] != 2'b00) || (pc_w < {1'b0, IM_BASE}) || (pc_w > IM_LAST);
  endfunction

  logic [31:0] ir_r,  ir_nxt_s;
  logic [31:0] pc_r,  pc_nxt_s;
  logic [31:0] pc4_r, pc4_nxt_s;
  logic        valid_r, valid_nxt_s;
  logic        bd_r,  bd_nxt_s;
  logic [4:0]  exc_r, exc_nxt_s;
  logic [31:0] cnt_r, cnt_nxt_s;
  logic        bad_s;

  // Next-state selection: flush beats stall, stall beats load.
  always_comb begin
    ir_nxt_s    = ir_r;
    pc_nxt_s    = pc_r;
    pc4_nxt_s   = pc4_r;
    valid_nxt_s = valid_r;
    bd_nxt_s    = bd_r;
    exc_nxt_s   = exc_r;
    cnt_nxt_s   = cnt_r;
    bad_s       = addr_bad(fd.pc_F);
    if (fd.flush) begin
      ir_nxt_s    = 32'h0000_0000;
      pc_nxt_s    = fd.pc_F;
      pc4_nxt_s   = fd.pc4_F;
      valid_nxt_s = 1'b0;
      bd_nxt_s    = 1'b0;
      exc_nxt_s   = EXC_NONE;
    end else if (fd.stall) begin
      ir_nxt_s    = ir_r;
      cnt_nxt_s   = cnt_r;
    end else begin
      pc_nxt_s    = fd.pc_F;
      pc4_nxt_s   = fd.pc4_F;
      valid_nxt_s = 1'b1;
      bd_nxt_s    = fd.is_jb_D;
      // A bad fetch stays valid so the AdEL reaches the exception logic.
      if (bad_s) begin
        ir_nxt_s  = 32'h0000_0000;
        exc_nxt_s = EXC_ADEL;
        cnt_nxt_s = cnt_r;
      end else begin
        ir_nxt_s  = fd.IR_F;
        exc_nxt_s = EXC_NONE;
        cnt_nxt_s = cnt_r + 32'd1;
      end
    end
  end

  // D-stage state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ir_r    <= 32'h0000_0000;
      pc_r    <= PC_RESET;
      pc4_r   <= PC_RESET + 32'd4;
      valid_r <= 1'b0;
      bd_r    <= 1'b0;
      exc_r   <= EXC_NONE;
      cnt_r   <= 32'h0000_0000;
    end else begin
      ir_r    <= ir_nxt_s;
      pc_r    <= pc_nxt_s;
      pc4_r   <= pc4_nxt_s;
      valid_r <= valid_nxt_s;
      bd_r    <= bd_nxt_s;
      exc_r   <= exc_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign fd.IR_D      = ir_r;
  assign fd.pc_D      = pc_r;
  assign fd.pc4_D     = pc4_r;
  assign fd.valid_D   = valid_r;
  assign fd.bd_D      = bd_r;
  assign fd.exc_D     = exc_r;
  assign fd.fetch_cnt = cnt_r;

endmodule
